// File: rtl/reaction_ctrl.sv
// Reaction timer control core: button conditioning, random-delay LFSR, 1 ms prescaler,
// round FSM, BCD reaction-time counter and best-score register.
module reaction_ctrl #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        react,
  output logic [1:0]  state,
  output logic [15:0] bcd_ms,
  output logic [15:0] best_ms,
  output logic        best_valid,
  output logic        false_start
);

  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DELAY_W = 12;
  localparam int unsigned BCD_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_TIMING = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          start_sync, react_sync;
  logic                start_p, react_p;
  logic [15:0]         lfsr_q;
  logic [PRE_W-1:0]    pre_q;
  logic                tick;
  logic                pre_clr;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BCD_W-1:0]    best_q, best_d;
  logic                bv_q, bv_d;
  logic                fs_q, fs_d;

  // Saturating packed-BCD increment with per-digit carry.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Two-flop synchronizers plus a third stage for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync <= 3'b000;
      react_sync <= 3'b000;
    end else begin
      start_sync <= {start_sync[1:0], start};
      react_sync <= {react_sync[1:0], react};
    end
  end

  assign start_p = start_sync[1] & ~start_sync[2];
  assign react_p = react_sync[1] & ~react_sync[2];

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  // Millisecond prescaler, realigned whenever WAIT or TIMING is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (pre_clr || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      bcd_q   <= '0;
      best_q  <= 16'h9999;
      bv_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      bcd_q   <= bcd_d;
      best_q  <= best_d;
      bv_q    <= bv_d;
      fs_q    <= fs_d;
    end
  end

  // Round sequencing; a react edge takes priority over a coincident tick.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    bcd_d   = bcd_q;
    best_d  = best_q;
    bv_d    = bv_q;
    fs_d    = fs_q;
    pre_clr = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_p) begin
          state_d = S_WAIT;
          delay_d = DELAY_W'(1024) + DELAY_W'(lfsr_q[10:0]);
          bcd_d   = '0;
          fs_d    = 1'b0;
          pre_clr = 1'b1;
        end
      end
      S_WAIT: begin
        if (react_p) begin
          state_d = S_IDLE;
          fs_d    = 1'b1;
        end else if (tick) begin
          delay_d = delay_q - DELAY_W'(1);
          if (delay_q == DELAY_W'(1)) begin
            state_d = S_TIMING;
            pre_clr = 1'b1;
          end
        end
      end
      S_TIMING: begin
        if (react_p) begin
          state_d = S_DONE;
          if (!bv_q || (bcd_q < best_q)) begin
            best_d = bcd_q;
            bv_d   = 1'b1;
          end
        end else if (tick) begin
          bcd_d = bcd_inc(bcd_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state       = state_q;
  assign bcd_ms      = bcd_q;
  assign best_ms     = best_q;
  assign best_valid  = bv_q;
  assign false_start = fs_q;

endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Control core of the reaction timer. It generates the 2-bit `state` code that the seven-segment display multiplexer consumes, the running reaction time as packed BCD milliseconds, and the best (high-score) time. It sits between the debounced push-button inputs and the BCD-to-seven-segment decoders and display mux.

## Interface

- `TICK_DIV`, default 50000: clock cycles per 1 ms tick (50 MHz board clock).
- `LFSR_SEED`, default 16'hACE1: reset value of the random-delay LFSR; must be non-zero.

- `clk`, input, 1: system clock, rising-edge.
- `reset`, input, 1: reset, asynchronous, active-high. One clock; all state resets asynchronously.
- `start`, input, 1: start/restart button, active-high, asynchronous to `clk`.
- `react`, input, 1: reaction button, active-high, asynchronous to `clk`.
- `state`, output, 2: display state code. 0 = IDLE, 1 = WAIT (display blanked), 2 = TIMING, 3 = DONE.
- `bcd_ms`, output, 16: current reaction time as 4 packed BCD digits [15:12] thousands down to [3:0] units.
- `best_ms`, output, 16: best reaction time, packed BCD.
- `best_valid`, output, 1: high once `best_ms` holds a real score.
- `false_start`, output, 1: high after `react` was pressed during WAIT.

## Operation

- Input conditioning on `start` and `react`:
  - 2-flop synchronizer, then a third register for edge detection.
  - Rising-edge pulse is `sync2 & ~sync3`, lasting one cycle.
  - All FSM actions use only these edge pulses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It free-runs every cycle, including in IDLE.
- ms tick: the prescaler counts 0..TICK_DIV-1 and the tick pulses on the cycle the count equals TICK_DIV-1. The prescaler clears on every entry to WAIT and TIMING.
- IDLE (0):
  - On a start edge: load `delay` = 1024 + lfsr[10:0] (1024..3071 ms), clear `bcd_ms` to 0, clear `false_start`, go to WAIT.
  - React edge is ignored.
- WAIT (1):
  - Each tick decrements `delay`.
  - On the tick where `delay` is 1, go to TIMING.
  - On a react edge: set `false_start`, go to IDLE. `bcd_ms` stays 0 and `best_ms` is unchanged.
  - Start edge is ignored.
- TIMING (2):
  - Each tick increments `bcd_ms` as a decimal counter with per-digit carry 9→0.
  - `bcd_ms` saturates at 16'h9999 (no wrap).
  - On a react edge: go to DONE. In the same clock, if `best_valid`=0 or `bcd_ms` < `best_ms`, load `best_ms` ← `bcd_ms` and set `best_valid`. Packed-BCD unsigned compare is valid.
  - Start edge is ignored.
- DONE (3):
  - Hold `bcd_ms`.
  - On a start edge: same action as from IDLE (new delay, clear `bcd_ms`, go to WAIT).
- Simultaneous events:
  - In WAIT, a react edge and the final tick in the same cycle → false start wins.
  - In TIMING, a react edge and a tick in the same cycle → the tick increment is not applied; the recorded time is the pre-tick value.
  - In DONE, start and react edges together → start wins; react is ignored.
- `best_ms` and `best_valid` are cleared only by `reset`.

## Timing

- Reset values:
  - `state`=0, `bcd_ms`=16'h0000, `best_ms`=16'h9999, `best_valid`=0, `false_start`=0.
  - LFSR=`LFSR_SEED`; prescaler, `delay` and sync registers all 0.
- Button latency: with an input rising before clock edge N, the edge pulse is high after edge N+1. `state` and the related outputs update at edge N+2.
- Time counting:
  - First TIMING tick occurs TICK_DIV cycles after entering TIMING.
  - WAIT duration is exactly `delay`×TICK_DIV cycles.
- All outputs are registered; none are combinational from inputs.
- `reset` asserted mid-operation forces all reset values immediately, regardless of `clk`. Operation resumes on the first rising `clk` after `reset` deasserts.

## Test plan

- Reset/idle: assert `reset` mid-TIMING → `state`=0, `bcd_ms`=0, `best_ms`=9999, `best_valid`=0 at once, without a clock edge.
- Normal round (TICK_DIV=4):
  - Press start → `state`=1 two edges after the sync stage, delay = 1024 + lfsr[10:0] computed from a bench model of the LFSR.
  - WAIT lasts delay×4 cycles.
  - Press react after 37 ticks in TIMING → `state`=3, `bcd_ms`=16'h0037, `best_ms`=16'h0037, `best_valid`=1.
- Best update: next round at 120 ticks → `best_ms` stays 16'h0037. A following round at 25 ticks → `best_ms`=16'h0025.
- False start: react during WAIT → `state`=0, `false_start`=1, `best_ms` unchanged. Next start edge clears `false_start`. React on the same cycle as the final WAIT tick → false start.
- Saturation/carry:
  - Hold TIMING for 10005 ticks → `bcd_ms`=16'h9999, no wrap.
  - Check the 0099→0100 and 0999→1000 carries.
- Ignored inputs:
  - Start edges in WAIT/TIMING change nothing.
  - React in IDLE changes nothing.
  - Start+react together in DONE → new round starts.
